// File: rtl/uart_pkg.sv
// Shared definitions for the UART AXI-Lite register block: register selects,
// status bit positions, control bits, response codes and FSM state types.
package uart_pkg;

   // Register select is addr[3:2]; the enum values are the word offsets.
   typedef enum logic [1:0] {
      REG_RX   = 2'd0,
      REG_TX   = 2'd1,
      REG_STAT = 2'd2,
      REG_CTRL = 2'd3
   } reg_sel_e;

   localparam int STAT_RX_NONEMPTY = 0;
   localparam int STAT_RX_FULL     = 1;
   localparam int STAT_TX_EMPTY    = 2;
   localparam int STAT_TX_FULL     = 3;
   localparam int STAT_OVERRUN     = 5;

   localparam int CTRL_TX_FLUSH = 0;
   localparam int CTRL_RX_FLUSH = 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WRITE,
      W_RESP
   } wr_state_e;

   function automatic logic [31:0] stat_word(
      input logic rx_empty,
      input logic rx_full,
      input logic tx_empty,
      input logic tx_full,
      input logic overrun
   );
      logic [31:0] w;
      w = '0;
      w[STAT_RX_NONEMPTY] = ~rx_empty;
      w[STAT_RX_FULL]     = rx_full;
      w[STAT_TX_EMPTY]    = tx_empty;
      w[STAT_TX_FULL]     = tx_full;
      w[STAT_OVERRUN]     = overrun;
      return w;
   endfunction

endpackage

// File: rtl/uart_axil_regs_if.sv
// AXI-Lite slave bus bundle for the UART register block; the bus master
// drives address/data/valid and response-ready, the slave drives the rest.
interface uart_axil_regs_if;

   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and a flush that
// overrides any same-cycle push or pop. A push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst && !flush && do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/uart_axil_regs.sv
// AXI-Lite register front end for a UART: RX/TX byte FIFOs, a status word
// with a sticky overrun flag, and a control register for FIFO flushes.
module uart_axil_regs
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   uart_axil_regs_if.slave   s_axi,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid
);

   rd_state_e   rd_state;
   wr_state_e   wr_state;

   logic        arready_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;

   logic        awready_q;
   logic        wready_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;
   reg_sel_e    aw_sel_q;
   logic [7:0]  wbyte_q;
   logic [1:0]  wctrl_q;
   logic        wstrb0_q;

   logic        overrun;

   logic        rx_full, rx_empty, rx_pop, rx_flush;
   logic [7:0]  rx_head;
   logic        tx_full, tx_empty, tx_pop, tx_push, tx_flush;
   logic [7:0]  tx_head;

   logic        ar_hs, aw_hs, w_hs;
   reg_sel_e    ar_sel;
   logic [31:0] rd_word;
   logic [1:0]  rd_resp;
   logic        stat_clr;
   logic [1:0]  wr_resp;
   logic        rx_overflow;

   logic        unused_bits;

   assign unused_bits = ^{s_axi.awaddr[31:4], s_axi.awaddr[1:0], s_axi.wdata[31:8],
                          s_axi.wstrb[3:1], s_axi.araddr[31:4], s_axi.araddr[1:0]};

   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;

   assign ar_hs  = s_axi.arvalid & arready_q;
   assign aw_hs  = s_axi.awvalid & awready_q;
   assign w_hs   = s_axi.wvalid & wready_q;
   assign ar_sel = reg_sel_e'(s_axi.araddr[3:2]);

   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_head;
   assign tx_pop   = tx_valid & tx_ready;

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_valid),
      .push_data (rx_data),
      .pop       (rx_pop),
      .flush     (rx_flush),
      .full      (rx_full),
      .empty     (rx_empty),
      .head      (rx_head)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push),
      .push_data (wbyte_q),
      .pop       (tx_pop),
      .flush     (tx_flush),
      .full      (tx_full),
      .empty     (tx_empty),
      .head      (tx_head)
   );

   // Read decode acts in the AR handshake cycle so the RX pop and the
   // overrun clear line up with the data being captured.
   always_comb begin
      rd_word  = '0;
      rd_resp  = RESP_OKAY;
      rx_pop   = 1'b0;
      stat_clr = 1'b0;
      if (ar_hs) begin
         unique case (ar_sel)
            REG_RX: begin
               if (!rx_empty) begin
                  rd_word = {24'b0, rx_head};
                  rx_pop  = 1'b1;
               end
            end
            REG_STAT: begin
               rd_word  = stat_word(rx_empty, rx_full, tx_empty, tx_full, overrun);
               stat_clr = 1'b1;
            end
            default: rd_resp = RESP_SLVERR;
         endcase
      end
   end

   always_comb begin
      tx_push  = 1'b0;
      tx_flush = 1'b0;
      rx_flush = 1'b0;
      wr_resp  = RESP_OKAY;
      if (wr_state == W_WRITE) begin
         unique case (aw_sel_q)
            REG_TX: begin
               if (wstrb0_q) begin
                  if (tx_full) begin
                     wr_resp = RESP_SLVERR;
                  end else begin
                     tx_push = 1'b1;
                  end
               end
            end
            REG_CTRL: begin
               tx_flush = wctrl_q[CTRL_TX_FLUSH];
               rx_flush = wctrl_q[CTRL_RX_FLUSH];
            end
            default: wr_resp = RESP_SLVERR;
         endcase
      end
   end

   assign rx_overflow = rx_valid & rx_full & ~rx_pop & ~rx_flush;

   // A fresh overrun in the same cycle as a STAT read wins over the clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         overrun <= 1'b0;
      end else if (rx_overflow) begin
         overrun <= 1'b1;
      end else if (stat_clr) begin
         overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_state  <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         unique case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata_q   <= rd_word;
                  rresp_q   <= rd_resp;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rd_state  <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi.rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rd_state  <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // AW and W are captured independently; a dropped ready marks a held beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_state  <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         aw_sel_q  <= REG_RX;
         wbyte_q   <= '0;
         wctrl_q   <= '0;
         wstrb0_q  <= 1'b0;
      end else begin
         unique case (wr_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_sel_q  <= reg_sel_e'(s_axi.awaddr[3:2]);
                  awready_q <= 1'b0;
               end
               if (w_hs) begin
                  wbyte_q  <= s_axi.wdata[7:0];
                  wctrl_q  <= s_axi.wdata[1:0];
                  wstrb0_q <= s_axi.wstrb[0];
                  wready_q <= 1'b0;
               end
               if ((!awready_q || aw_hs) && (!wready_q || w_hs)) begin
                  wr_state <= W_WRITE;
               end
            end
            W_WRITE: begin
               bresp_q  <= wr_resp;
               bvalid_q <= 1'b1;
               wr_state <= W_RESP;
            end
            W_RESP: begin
               if (s_axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  wr_state  <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_axil_regs.sv
// Scoreboard bench for uart_axil_regs: drivers push expected responses from a
// queue-based register model; a negedge monitor compares every handshake.
module tb_uart_axil_regs;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;

   uart_axil_regs_if bus();

   uart_axil_regs #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_axi    (bus),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_exp_t;

   int         n_vec = 0;
   int         n_err = 0;
   rd_exp_t    exp_r[$];
   logic [1:0] exp_b[$];
   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   bit         ovr = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void fail_event(input string name, input string what);
      n_vec++;
      n_err++;
      $display("[TB] FAIL %s: got %s", name, what);
   endfunction

   // Reference model: the register map expressed as queue operations.
   function automatic logic [31:0] model_stat();
      logic [31:0] w;
      w = '0;
      w[0] = (rxq.size() != 0);
      w[1] = (rxq.size() == DEPTH);
      w[2] = (txq.size() == 0);
      w[3] = (txq.size() == DEPTH);
      w[5] = ovr;
      return w;
   endfunction

   function automatic void model_read(input logic [31:0] addr, output logic [31:0] data,
                                      output logic [1:0] resp);
      data = '0;
      resp = 2'b00;
      case (addr[3:2])
         2'd0: if (rxq.size() != 0) data = {24'b0, rxq.pop_front()};
         2'd2: begin
            data = model_stat();
            ovr  = 1'b0;
         end
         default: resp = 2'b10;
      endcase
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, output logic [1:0] resp);
      resp = 2'b00;
      case (addr[3:2])
         2'd1: begin
            if (strb[0]) begin
               if (txq.size() == DEPTH) resp = 2'b10;
               else txq.push_back(data[7:0]);
            end
         end
         2'd3: begin
            if (data[0]) txq.delete();
            if (data[1]) rxq.delete();
         end
         default: resp = 2'b10;
      endcase
   endfunction

   function automatic void model_rx(input logic [7:0] b);
      if (rxq.size() < DEPTH) rxq.push_back(b);
      else ovr = 1'b1;
   endfunction

   task automatic axi_read(input logic [31:0] addr, input int r_delay);
      logic [31:0] d;
      logic [1:0]  r;
      int          n;
      model_read(addr, d, r);
      exp_r.push_back('{d, r});
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.arready) break;
         if (++n > 50) begin
            fail_event("ar_handshake", "timeout, want arready");
            break;
         end
      end
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      repeat (r_delay) begin @(posedge clk); #1; end
      bus.rready = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.rvalid) break;
         if (++n > 50) begin
            fail_event("r_handshake", "timeout, want rvalid");
            break;
         end
      end
      @(posedge clk); #1;
      bus.rready = 1'b0;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, input int b_delay,
                            input bit rx_too, input logic [7:0] rx_b);
      logic [1:0] resp;
      int         n;
      if (rx_too) model_rx(rx_b);
      model_write(addr, data, strb, resp);
      exp_b.push_back(resp);
      fork
         begin
            int na;
            na = 0;
            repeat (aw_delay) begin @(posedge clk); #1; end
            bus.awaddr  = addr;
            bus.awvalid = 1'b1;
            if (rx_too) begin
               rx_data  = rx_b;
               rx_valid = 1'b1;
            end
            forever begin
               @(negedge clk);
               if (bus.awready) break;
               if (++na > 50) begin
                  fail_event("aw_handshake", "timeout, want awready");
                  break;
               end
            end
            @(posedge clk); #1;
            bus.awvalid = 1'b0;
            rx_valid    = 1'b0;
         end
         begin
            int nw;
            nw = 0;
            repeat (w_delay) begin @(posedge clk); #1; end
            bus.wdata  = data;
            bus.wstrb  = strb;
            bus.wvalid = 1'b1;
            forever begin
               @(negedge clk);
               if (bus.wready) break;
               if (++nw > 50) begin
                  fail_event("w_handshake", "timeout, want wready");
                  break;
               end
            end
            @(posedge clk); #1;
            bus.wvalid = 1'b0;
         end
      join
      repeat (b_delay) begin @(posedge clk); #1; end
      bus.bready = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus.bvalid) break;
         if (++n > 50) begin
            fail_event("b_handshake", "timeout, want bvalid");
            break;
         end
      end
      @(posedge clk); #1;
      bus.bready = 1'b0;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      model_rx(b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      tx_ready = 1'b1;
      @(posedge clk); #1;
      while (txq.size() != 0) begin
         @(posedge clk); #1;
         if (++n > 4 * DEPTH) begin
            fail_event("tx_drain", "timeout, want all model bytes popped");
            txq.delete();
            break;
         end
      end
      tx_ready = 1'b0;
      check("tx_valid_after_drain", {31'b0, tx_valid}, 32'h0);
   endtask

   // Monitor: every handshake pops the matching expectation.
   always @(negedge clk) begin
      rd_exp_t e;
      if (rst) begin
         if (bus.bvalid && bus.bready) begin
            if (exp_b.size() == 0) fail_event("bresp_unexpected", "response with empty queue, want none");
            else check("bresp", {30'b0, bus.bresp}, {30'b0, exp_b.pop_front()});
         end
         if (bus.rvalid && bus.rready) begin
            if (exp_r.size() == 0) begin
               fail_event("rdata_unexpected", "response with empty queue, want none");
            end else begin
               e = exp_r.pop_front();
               check("rdata", bus.rdata, e.data);
               check("rresp", {30'b0, bus.rresp}, {30'b0, e.resp});
            end
         end
         if (tx_valid && tx_ready) begin
            if (txq.size() == 0) fail_event("tx_unexpected", "byte with empty model, want none");
            else check("tx_data", {24'b0, tx_data}, {24'b0, txq.pop_front()});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no finish, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          op;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;

      rst         = 1'b0;
      bus.awaddr  = '0;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      tx_ready    = 1'b0;
      rx_data     = '0;
      rx_valid    = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", {31'b0, bus.awready}, 32'h1);
      check("rst_wready",  {31'b0, bus.wready},  32'h1);
      check("rst_arready", {31'b0, bus.arready}, 32'h1);
      check("rst_bvalid",  {31'b0, bus.bvalid},  32'h0);
      check("rst_rvalid",  {31'b0, bus.rvalid},  32'h0);
      check("rst_bresp",   {30'b0, bus.bresp},   32'h0);
      check("rst_rresp",   {30'b0, bus.rresp},   32'h0);
      check("rst_rdata",   bus.rdata,            32'h0);
      check("rst_tx_valid", {31'b0, tx_valid},   32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      $display("[TB] status after reset");
      axi_read(32'h8, 0);

      $display("[TB] single rx byte");
      rx_byte(8'h41);
      axi_read(32'h0, 1);
      axi_read(32'h8, 0);

      $display("[TB] split AW/W write to TX");
      axi_write(32'h4, 32'h5A, 4'hF, 0, 3, 0, 1'b0, 8'h00);
      check("tx_valid_after_write", {31'b0, tx_valid}, 32'h1);
      check("tx_data_after_write", {24'b0, tx_data}, 32'h5A);
      drain();

      $display("[TB] TX fill past full");
      for (int i = 0; i < DEPTH + 1; i++) begin
         axi_write(32'h4, $urandom, 4'h1, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, 8'h00);
      end
      axi_read(32'h8, 0);
      drain();

      $display("[TB] RX overrun");
      axi_write(32'h4, 32'hC3, 4'h1, 0, 0, 0, 1'b0, 8'h00);
      for (int i = 0; i < DEPTH + 1; i++) rx_byte(8'($urandom));
      axi_read(32'h8, 0);
      axi_read(32'h8, 0);

      $display("[TB] flush both FIFOs with concurrent rx byte");
      axi_read(32'h0, 0);
      axi_write(32'hC, 32'h3, 4'hF, 0, 0, 0, 1'b1, 8'h99);
      axi_read(32'h8, 0);

      $display("[TB] randomized traffic");
      repeat (400) begin
         op = $urandom_range(0, 9);
         a  = $urandom;
         d  = $urandom;
         s  = 4'($urandom);
         if (op <= 3) begin
            if ($urandom_range(0, 1) == 1) a[3:2] = 2'd1;
            if ($urandom_range(0, 3) != 0) s[0] = 1'b1;
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'b0, 8'h00);
         end else if (op <= 6) begin
            if ($urandom_range(0, 1) == 1) a[3] = 1'b0;
            axi_read(a, $urandom_range(0, 3));
         end else if (op <= 8) begin
            rx_byte(8'(d));
         end else begin
            drain();
         end
      end
      drain();

      $display("[TB] reset during outstanding read and write");
      bus.araddr  = 32'h8;
      bus.arvalid = 1'b1;
      bus.awaddr  = 32'h4;
      bus.awvalid = 1'b1;
      bus.wdata   = 32'h77;
      bus.wstrb   = 4'h1;
      bus.wvalid  = 1'b1;
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      rst         = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      rxq.delete();
      txq.delete();
      ovr = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rvalid_after_reset", {31'b0, bus.rvalid}, 32'h0);
         check("bvalid_after_reset", {31'b0, bus.bvalid}, 32'h0);
         check("tx_valid_after_reset", {31'b0, tx_valid}, 32'h0);
      end
      @(posedge clk); #1;
      axi_read(32'h8, 0);

      repeat (3) @(posedge clk);
      check("rd_queue_drained", exp_r.size(), 32'h0);
      check("wr_queue_drained", exp_b.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
